// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;

  localparam int InstBus       = 32;
  localparam int InstAddrBus   = 32;
  localparam int Hold_Flag_Bus = 3;

  localparam logic [InstBus-1:0]     INST_NOP = 32'h0000_0013;
  localparam logic [InstAddrBus-1:0] ZeroWord = 32'h0000_0000;

  // Hold levels; fetch stalls its output at Hold_If and above.
  localparam logic [Hold_Flag_Bus-1:0] Hold_None = 3'b000;
  localparam logic [Hold_Flag_Bus-1:0] Hold_Pc   = 3'b001;
  localparam logic [Hold_Flag_Bus-1:0] Hold_If   = 3'b010;
  localparam logic [Hold_Flag_Bus-1:0] Hold_Id   = 3'b011;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

  // One prefetched instruction with the address it came from.
  typedef struct packed {
    logic [InstAddrBus-1:0] addr;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

  function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] a);
    return {a[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO holding {addr, inst} pairs; DEPTH must be a power of two.
module ifu_fifo
  import ifu_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  fetch_entry_t           wdata_i,
  output fetch_entry_t           rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  fetch_entry_t  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping; clear drops everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a
// req/gnt/rvalid bus and feeds IF/ID from a small prefetch FIFO.
// Define IFU_BYPASS_EN to forward a response straight to the output when
// the FIFO is empty (1-cycle gnt-to-output latency instead of 2).
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     jump_flag_i,
  input  logic [InstAddrBus-1:0]   jump_addr_i,
  input  logic [Hold_Flag_Bus-1:0] hold_flag_i,
  output logic                     ibus_req_o,
  output logic [InstAddrBus-1:0]   ibus_addr_o,
  input  logic                     ibus_gnt_i,
  input  logic                     ibus_rvalid_i,
  input  logic [InstBus-1:0]       ibus_rdata_i,
  output logic [InstBus-1:0]       inst_o,
  output logic [InstAddrBus-1:0]   inst_addr_o,
  output logic                     inst_valid_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e           state_q;
  logic [InstAddrBus-1:0] pc_q, addr_q;
  logic                   req_q, kill_q;

  logic [CW-1:0]          fifo_cnt;
  fetch_entry_t           head, wentry;
  logic                   fifo_empty, fifo_full;
  logic [InstAddrBus-1:0] jump_tgt;
  logic                   hold_if, rsp_ok, bypass, push, pop;

  assign jump_tgt = word_align(jump_addr_i);
  assign hold_if  = (hold_flag_i >= Hold_If);
  // A response is usable only if no jump has invalidated it.
  assign rsp_ok   = (state_q == FETCH_WAIT) && ibus_rvalid_i && !kill_q && !jump_flag_i;

`ifdef IFU_BYPASS_EN
  assign bypass = rsp_ok && fifo_empty && !hold_if;
`else
  assign bypass = 1'b0;
`endif

  assign push   = rsp_ok && !bypass && !fifo_full;
  assign pop    = !fifo_empty && !hold_if && !jump_flag_i;
  assign wentry = '{addr: addr_q, inst: ibus_rdata_i};

  assign ibus_req_o  = req_q;
  assign ibus_addr_o = addr_q;

  ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (jump_flag_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wentry),
    .rdata_o (head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Fetch FSM: one outstanding request; a jump redirects pc and kills the
  // request in flight, which still completes on the bus before being dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      if (jump_flag_i) pc_q <= jump_tgt;
      case (state_q)
        FETCH_IDLE: begin
          if (!jump_flag_i && (fifo_cnt < CW'(FIFO_DEPTH))) begin
            state_q <= FETCH_REQ;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        FETCH_REQ: begin
          if (jump_flag_i) kill_q <= 1'b1;
          if (ibus_gnt_i) begin
            state_q <= FETCH_WAIT;
            req_q   <= 1'b0;
            // A killed request must not advance pc past the jump target.
            if (!jump_flag_i && !kill_q) pc_q <= pc_q + 32'd4;
          end
        end
        FETCH_WAIT: begin
          if (ibus_rvalid_i) begin
            kill_q  <= 1'b0;
            state_q <= FETCH_IDLE;
          end else if (jump_flag_i) begin
            kill_q <= 1'b1;
          end
        end
        default: state_q <= FETCH_IDLE;
      endcase
    end
  end

  // Output stage: FIFO head, else a bypassed response, else a NOP bubble.
  always_comb begin
    inst_o       = INST_NOP;
    inst_addr_o  = ZeroWord;
    inst_valid_o = 1'b0;
    if (!fifo_empty) begin
      inst_o       = head.inst;
      inst_addr_o  = head.addr;
      inst_valid_o = 1'b1;
    end else if (bypass) begin
      inst_o       = ibus_rdata_i;
      inst_addr_o  = addr_q;
      inst_valid_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a bus responder plus a queue-based
// model of the instruction stream, driven by directed and random steps.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam int DEPTH = 2;
`ifdef IFU_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0;
  logic        jump_flag = 1'b0;
  logic [31:0] jump_addr = '0;
  logic [2:0]  hold = '0;
  logic        req, gnt = 1'b0, rvalid = 1'b0, valid;
  logic [31:0] addr, rdata = '0, inst, inst_addr;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
    .hold_flag_i(hold), .ibus_req_o(req), .ibus_addr_o(addr), .ibus_gnt_i(gnt),
    .ibus_rvalid_i(rvalid), .ibus_rdata_i(rdata), .inst_o(inst),
    .inst_addr_o(inst_addr), .inst_valid_o(valid)
  );

  typedef struct packed { logic [31:0] a; logic [31:0] d; } word_t;

  int          ncmp = 0, nerr = 0;
  word_t       q[$];
  logic [31:0] next_fetch, out_addr, prev_addr, kaddr;
  int          epoch, req_epoch, out_epoch, rv_wait, req_age;
  int          gnt_mode, gnt_dly, rv_dly;
  logic        out_pend, prev_req, prev_gnt;
  logic        s_req, s_req_start, s_valid, s_rvalid;
  logic [31:0] s_raddr, s_inst, s_iaddr;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h1111_1111;
    if (a == 32'h4) return 32'h2222_2222;
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    next_fetch = 32'h0; epoch = 0; req_epoch = 0; out_epoch = -1;
    out_pend = 1'b0; out_addr = '0; rv_wait = 0; req_age = 0;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_addr = '0;
  endtask

  // One cycle, entered and left at the falling edge.
  task automatic step();
    logic        live, byp, qe, exp_v;
    logic [31:0] exp_i, exp_a;
    word_t       w;
    gnt = 1'b0;
    if (req) begin
      case (gnt_mode)
        0:       gnt = 1'b1;
        1:       gnt = (req_age >= gnt_dly);
        default: gnt = ($urandom_range(0, 2) == 0);
      endcase
    end
    rvalid = out_pend && (rv_wait == 0);
    rdata  = rvalid ? mem(out_addr) : $urandom;
    #1;
    s_req = req; s_raddr = addr; s_valid = valid; s_inst = inst; s_iaddr = inst_addr;
    s_rvalid = rvalid; s_req_start = req && !prev_req;
    chk("addr_align", {30'd0, addr[1:0]}, 32'd0);
    if (req && prev_req && !prev_gnt) chk("req_addr_stable", addr, prev_addr);
    if (req) chk("one_outstanding", {31'd0, out_pend}, 32'd0);
    if (s_req_start) begin
      chk("fetch_addr", addr, next_fetch);
      chk("issue_room", {31'd0, q.size() < DEPTH}, 32'd1);
      next_fetch = next_fetch + 32'd4;
      req_epoch  = epoch;
    end
    live = rvalid && (out_epoch == epoch) && !jump_flag;
    qe   = (q.size() == 0);
    byp  = BYP && qe && live && (hold < Hold_If);
    if (!qe)      {exp_v, exp_i, exp_a} = {1'b1, q[0].d, q[0].a};
    else if (byp) {exp_v, exp_i, exp_a} = {1'b1, mem(out_addr), out_addr};
    else          {exp_v, exp_i, exp_a} = {1'b0, 32'h0000_0013, 32'h0};
    chk("inst_valid", {31'd0, valid}, {31'd0, exp_v});
    chk("inst", inst, exp_i);
    chk("inst_addr", inst_addr, exp_a);
    if (exp_v && (hold < Hold_If) && !qe) void'(q.pop_front());
    if (live && !byp) begin
      w.a = out_addr; w.d = mem(out_addr);
      q.push_back(w);
    end
    if (jump_flag) begin
      q.delete();
      epoch++;
      next_fetch = {jump_addr[31:2], 2'b00};
    end
    chk("fifo_bound", {31'd0, q.size() <= DEPTH}, 32'd1);
    if (rvalid) out_pend = 1'b0;
    else if (out_pend) rv_wait--;
    if (gnt) begin
      out_pend = 1'b1; out_addr = addr; out_epoch = req_epoch;
      rv_wait  = (rv_dly < 0) ? int'($urandom_range(0, 2)) : rv_dly;
    end
    req_age   = (req && !gnt) ? req_age + 1 : 0;
    prev_req  = req; prev_gnt = gnt; prev_addr = addr;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int   nv, nreq;
    logic found, rv_seen;
    logic [31:0] head_a, last_a;
    gnt_mode = 0; gnt_dly = 0; rv_dly = 0;
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_addr", inst_addr, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    rst = 1'b1;

    // First fetches after reset release
    found = 1'b0; nv = 0;
    for (int i = 0; i < 30 && nv < 2; i++) begin
      step();
      if (i == 0) chk("a_valid_low_first", {31'd0, s_valid}, 32'd0);
      if (s_req_start && !found) begin found = 1'b1; chk("a_first_req", s_raddr, 32'h0); end
      if (s_valid) begin
        chk(nv == 0 ? "a_word0" : "a_word1", s_inst, nv == 0 ? 32'h1111_1111 : 32'h2222_2222);
        chk(nv == 0 ? "a_addr0" : "a_addr1", s_iaddr, nv == 0 ? 32'h0 : 32'h4);
        nv++;
      end
    end
    if (nv < 2) chk("a_timeout", 32'd0, 32'd1);

    // Hold for 5 cycles: head frozen, then order preserved
    hold = Hold_If; found = 1'b0; head_a = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (s_valid && !found) begin found = 1'b1; head_a = s_iaddr; end
      else if (s_valid) chk("b_head_frozen", s_iaddr, head_a);
    end
    hold = Hold_None; found = 1'b0; last_a = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_valid) begin
        if (found) chk("b_order", s_iaddr, last_a + 32'd4);
        found = 1'b1; last_a = s_iaddr;
      end
    end

    // Jump while waiting, response due next cycle
    rv_dly = 1; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_pend && rv_wait > 0) found = 1'b1; else step();
    end
    if (!found) chk("c_timeout", 32'd0, 32'd1);
    jump_flag = 1'b1; jump_addr = 32'h8000_0102; step(); jump_flag = 1'b0;
    chk("c_drop_valid", {31'd0, s_valid}, {31'd0, (q.size() != 0)});
    rv_dly = 0; found = 1'b0; nv = 0;
    for (int i = 0; i < 20 && nv == 0; i++) begin
      step();
      if (s_req_start && !found) begin found = 1'b1; chk("c_target_req", s_raddr, 32'h8000_0100); end
      if (s_valid) begin nv++; chk("c_resume_addr", s_iaddr, 32'h8000_0100); end
    end
    if (nv == 0) chk("c_resume_timeout", 32'd0, 32'd1);

    // Jump while request pending, gnt delayed 3 cycles
    gnt_mode = 1; gnt_dly = 3; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (req && !prev_req) found = 1'b1; else step();
    end
    if (!found) chk("d_timeout", 32'd0, 32'd1);
    kaddr = addr;
    jump_flag = 1'b1; jump_addr = 32'h0000_0400; step(); jump_flag = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (s_req_start) begin found = 1'b1; chk("d_target_req", s_raddr, 32'h400); end
      else if (s_req) chk("d_old_addr_held", s_raddr, kaddr);
    end
    if (!found) chk("d_target_timeout", 32'd0, 32'd1);

    // Jump in the same cycle as rvalid and a pop
    gnt_mode = 0; rv_dly = 0; hold = Hold_If; found = 1'b0;
    for (int i = 0; i < 20 && q.size() < DEPTH; i++) step();
    hold = Hold_None; step(); hold = Hold_If;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_pend && rv_wait == 0 && q.size() > 0) found = 1'b1; else step();
    end
    if (!found) chk("e_timeout", 32'd0, 32'd1);
    hold = Hold_None; jump_flag = 1'b1; jump_addr = 32'h0000_0200;
    step(); jump_flag = 1'b0;
    step();
    chk("e_valid_after_jump", {31'd0, s_valid}, 32'd0);

    // pc wrap at the top of the address space
    jump_flag = 1'b1; jump_addr = 32'hFFFF_FFFE; step(); jump_flag = 1'b0;
    nreq = 0; rv_seen = 1'b0;
    for (int i = 0; i < 30 && nreq < 2; i++) begin
      step();
      if (nreq == 1 && s_rvalid && !rv_seen) begin
        rv_seen = 1'b1;
        chk("f_rvalid_cycle_valid", {31'd0, s_valid}, {31'd0, BYP});
      end
      if (s_req_start) begin
        nreq++;
        chk(nreq == 1 ? "f_req_top" : "f_req_wrap", s_raddr, nreq == 1 ? 32'hFFFF_FFFC : 32'h0);
      end
    end
    if (nreq < 2) chk("f_timeout", 32'd0, 32'd1);

    // Random traffic
    gnt_mode = 2; rv_dly = -1;
    for (int i = 0; i < 400; i++) begin
      hold = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      jump_flag = ($urandom_range(0, 24) == 0);
      jump_addr = $urandom;
      step();
    end
    jump_flag = 1'b0; hold = Hold_None;

    // Reset mid-transaction, late rvalid ignored
    gnt_mode = 0; rv_dly = 1; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (out_pend && rv_wait > 0) found = 1'b1; else step();
    end
    if (!found) chk("h_timeout", 32'd0, 32'd1);
    rst = 1'b0; #1;
    chk("h_rst_req", {31'd0, req}, 32'd0);
    chk("h_rst_addr", addr, 32'h0);
    chk("h_rst_valid", {31'd0, valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; #1;
    chk("h_late_rvalid_valid", {31'd0, valid}, 32'd0);
    chk("h_late_rvalid_inst", inst, 32'h0000_0013);
    @(posedge clk); @(negedge clk);
    rvalid = 1'b0; rv_dly = 0;
    model_reset();
    nv = 0;
    for (int i = 0; i < 20 && nv == 0; i++) begin
      step();
      if (s_valid) begin
        nv++;
        chk("h_restart_addr", s_iaddr, 32'h0);
        chk("h_restart_inst", s_inst, 32'h1111_1111);
      end
    end
    if (nv == 0) chk("h_restart_timeout", 32'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
